inst_sram_slave: RTL

Memory-side responder for the fetch stage's instruction-memory port, upgraded to the request/response (addr_ok/data_ok) SRAM-like handshake. The block accepts in-order read and write requests into a bounded outstanding queue. It services each request from an internal word-addressed memory array and returns one response per request after a fixed, parameterised latency. It sits between the IF stage and instruction storage, and lets the pipeline be exercised against non-zero-latency memory before an AXI bridge exists.

---
 rtl/inst_sram_slave.sv | 95 +++++++++
 1 files changed

// File: rtl/inst_sram_slave.sv
// rtl/inst_sram_slave.sv - instruction-memory responder with addr_ok/data_ok handshake
// Word-addressed array behind a bounded in-order queue of timed responses.
module inst_sram_slave #(
   parameter int          ADDR_W  = 14,
   parameter int          LATENCY = 1,
   parameter int          DEPTH   = 2,
   parameter logic [31:0] BASE    = 32'h1c000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        data_err
);
   localparam int          PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CW    = $clog2(DEPTH + 1);
   localparam logic [2:0]  TLOAD = 3'(LATENCY - 1);

   logic [31:0]       mem [2**ADDR_W];
   logic [31:0]       q_data [DEPTH];
   logic              q_err [DEPTH];
   logic [2:0]        q_timer [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     count;
   logic [31:0]       last_rdata;
   logic              last_err;
   logic              accept;
   logic              pop;
   logic              misaligned;
   logic              out_of_range;
   logic              err;
   logic [ADDR_W-1:0] index;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign addr_ok      = !reset && (count < CW'(DEPTH));
   assign accept       = req && addr_ok;
   assign index        = addr[ADDR_W+1:2];
   assign misaligned   = (size == 2'd1 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
   assign out_of_range = addr[31:ADDR_W+2] != BASE[31:ADDR_W+2];
   assign err          = misaligned || out_of_range;

   // Reset gates the head so pending entries never surface during the reset cycle.
   assign data_ok  = !reset && (count != '0) && (q_timer[head] == 3'd0);
   assign pop      = data_ok;
   assign rdata    = data_ok ? q_data[head] : last_rdata;
   assign data_err = data_ok ? q_err[head] : last_err;

   always_ff @(posedge clk) begin
      if (accept && wr && !err) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[index][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (q_timer[i] != 3'd0) q_timer[i] <= q_timer[i] - 3'd1;
      end
      if (accept) begin
         q_timer[tail] <= TLOAD;
         q_data[tail]  <= (!wr && !err) ? mem[index] : 32'h0;
         q_err[tail]   <= err;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         last_rdata <= 32'h0;
         last_err   <= 1'b0;
      end else begin
         if (accept) tail <= wrap_inc(tail);
         if (pop) begin
            head       <= wrap_inc(head);
            last_rdata <= q_data[head];
            last_err   <= q_err[head];
         end
         count <= count + CW'(accept) - CW'(pop);
      end
   end
endmodule
